alu_flag_unit: RTL and testbench

Sequential consumer of the ALU's result and flag outputs in the 8-bit teaching CPU. Captures the ALU result into the accumulator and its flags into a 5-bit status register. Resolves branch condition requests from the control unit over a valid/ready/ack handshake. Optionally saves and restores flags on a small stack for interrupt entry and return.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/alu_flag_unit_cond_eval.sv | 49 ++++
 rtl/alu_flag_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_flag_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit teaching CPU: condition codes, status flag
// bit positions, the branch-resolution FSM encoding and a flag merge helper.
package cpu_pkg;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_NV = 4'd1;
  localparam logic [3:0] COND_EQ = 4'd2;
  localparam logic [3:0] COND_NE = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_CS = 4'd8;
  localparam logic [3:0] COND_CC = 4'd9;
  localparam logic [3:0] COND_LT = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_HI = 4'd14;
  localparam logic [3:0] COND_LS = 4'd15;

  localparam int unsigned FLAG_C = 32'd4;
  localparam int unsigned FLAG_V = 32'd3;
  localparam int unsigned FLAG_S = 32'd2;
  localparam int unsigned FLAG_N = 32'd1;
  localparam int unsigned FLAG_Z = 32'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Bits selected by the mask come from the incoming flags, the rest are kept.
  function automatic logic [4:0] f_merge_flags(input logic [4:0] i_in_flags,
                                               input logic [4:0] i_cur_flags,
                                               input logic [4:0] i_mask);
    return (i_in_flags & i_mask) | (i_cur_flags & ~i_mask);
  endfunction

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// cond_eval: purely combinational branch condition decoder over a {C,V,S,N,Z}
// flag vector.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_taken
);

  logic w_c;
  logic w_v;
  logic w_n;
  logic w_z;
  logic w_lt;
  logic w_unused_s;

  assign w_c        = i_flags[FLAG_C];
  assign w_v        = i_flags[FLAG_V];
  assign w_n        = i_flags[FLAG_N];
  assign w_z        = i_flags[FLAG_Z];
  assign w_lt       = w_n ^ w_v;
  assign w_unused_s = i_flags[FLAG_S];

  // Condition code decode
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = ~w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = ~w_v;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = ~w_c;
      COND_LT: o_taken = w_lt;
      COND_GE: o_taken = ~w_lt;
      COND_GT: o_taken = ~w_z & ~w_lt;
      COND_LE: o_taken = w_z | w_lt;
      COND_HI: o_taken = w_c & ~w_z;
      COND_LS: o_taken = ~w_c | w_z;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: accumulator/status capture and branch resolution for the 8-bit CPU.
// Define ALU_FLAG_STACK_EN to build the 4-entry flag save/restore stack.
module alu_flag_unit
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_res_valid,
  input  logic [7:0] i_res,
  input  logic       i_s,
  input  logic       i_v,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_c,
  input  logic [4:0] i_flag_we,
  input  logic       i_cond_valid,
  input  logic [3:0] i_cond,
  output logic       o_cond_ready,
  output logic       o_taken_valid,
  output logic       o_taken,
  input  logic       i_taken_ack,
  input  logic       i_push,
  input  logic       i_pop,
  output logic       o_stack_full,
  output logic       o_stack_empty,
  output logic       o_stack_err,
  output logic [7:0] o_acc,
  output logic [4:0] o_flags
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_acc;
  logic [4:0] r_flags;
  logic [4:0] w_in_flags;
  logic [4:0] w_merged_flags;
  logic [4:0] w_next_flags;
  logic       r_taken;
  logic       w_eval_taken;

  assign w_in_flags = {i_c, i_v, i_s, i_n, i_z};

  // Flags as they will be after this edge's ALU write
  always_comb begin
    w_merged_flags = r_flags;
    if (i_res_valid) begin
      w_merged_flags = f_merge_flags(w_in_flags, r_flags, i_flag_we);
    end else begin
      w_merged_flags = r_flags;
    end
  end

`ifdef ALU_FLAG_STACK_EN
  logic [4:0] r_stack [0:3];
  logic [2:0] r_sp;
  logic       r_err;
  logic       w_do_push;
  logic       w_do_pop;
  logic [1:0] w_top_idx;

  // Simultaneous push and pop cancel out entirely.
  assign w_do_push = i_push & ~i_pop;
  assign w_do_pop  = i_pop & ~i_push;
  assign w_top_idx = r_sp[1:0] - 2'd1;

  // A valid pop takes precedence over the ALU flag write
  always_comb begin
    w_next_flags = w_merged_flags;
    if (w_do_pop && (r_sp != 3'd0)) begin
      w_next_flags = r_stack[w_top_idx];
    end else begin
      w_next_flags = w_merged_flags;
    end
  end

  // Flag stack storage, pointer and sticky error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sp  <= 3'd0;
      r_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_stack[i] <= 5'd0;
      end
    end else if (w_do_push) begin
      if (r_sp == 3'd4) begin
        r_err <= 1'b1;
      end else begin
        r_stack[r_sp[1:0]] <= r_flags;
        r_sp               <= r_sp + 3'd1;
      end
    end else if (w_do_pop) begin
      if (r_sp == 3'd0) begin
        r_err <= 1'b1;
      end else begin
        r_sp <= r_sp - 3'd1;
      end
    end else begin
      r_sp <= r_sp;
    end
  end

  assign o_stack_full  = (r_sp == 3'd4);
  assign o_stack_empty = (r_sp == 3'd0);
  assign o_stack_err   = r_err;
`else
  logic w_unused_stack;

  assign w_unused_stack = i_push ^ i_pop;
  assign w_next_flags   = w_merged_flags;
  assign o_stack_full   = 1'b0;
  assign o_stack_empty  = 1'b1;
  assign o_stack_err    = 1'b0;
`endif

  cond_eval u_cond_eval (
    .i_cond  (i_cond),
    .i_flags (w_next_flags),
    .o_taken (w_eval_taken)
  );

  // Accumulator and status register capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc   <= 8'd0;
      r_flags <= 5'd0;
    end else begin
      r_flags <= w_next_flags;
      if (i_res_valid) begin
        r_acc <= i_res;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  // Request FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_cond_valid) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (i_taken_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decision is latched only on acceptance and then held through RESP
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_taken <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_cond_valid) begin
      r_taken <= w_eval_taken;
    end else begin
      r_taken <= r_taken;
    end
  end

  assign o_cond_ready  = (r_state == ST_IDLE);
  assign o_taken_valid = (r_state == ST_RESP);
  assign o_taken       = r_taken;
  assign o_acc         = r_acc;
  assign o_flags       = r_flags;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed, table-driven bench for alu_flag_unit; stack checks follow ALU_FLAG_STACK_EN.
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       reset, res_valid, s, v, n, z, c, cond_valid, taken_ack, push, pop;
  logic [7:0] res;
  logic [4:0] flag_we;
  logic [3:0] cond;
  logic       cond_ready, taken_valid, taken, stack_full, stack_empty, stack_err;
  logic [7:0] acc;
  logic [4:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_flag_unit dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_res_valid   (res_valid),
    .i_res         (res),
    .i_s           (s),
    .i_v           (v),
    .i_n           (n),
    .i_z           (z),
    .i_c           (c),
    .i_flag_we     (flag_we),
    .i_cond_valid  (cond_valid),
    .i_cond        (cond),
    .o_cond_ready  (cond_ready),
    .o_taken_valid (taken_valid),
    .o_taken       (taken),
    .i_taken_ack   (taken_ack),
    .i_push        (push),
    .i_pop         (pop),
    .o_stack_full  (stack_full),
    .o_stack_empty (stack_empty),
    .o_stack_err   (stack_err),
    .o_acc         (acc),
    .o_flags       (flags)
  );

  typedef struct {
    logic       rv;
    logic [7:0] res;
    logic [4:0] fin;
    logic [4:0] we;
    logic [3:0] cond;
    logic [7:0] exp_acc;
    logic [4:0] exp_flags;
    logic       exp_taken;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_alu(input logic rv, input logic [7:0] r, input logic [4:0] f, input logic [4:0] we);
    res_valid = rv;
    res       = r;
    {c, v, s, n, z} = f;
    flag_we   = we;
  endtask

  initial begin
    reset = 1'b1; res_valid = 1'b0; res = 8'd0; {c, v, s, n, z} = 5'd0;
    flag_we = 5'd0; cond_valid = 1'b0; cond = 4'd0; taken_ack = 1'b0;
    push = 1'b0; pop = 1'b0;

    //            rv    res    fin       we        cond   acc    flags     taken
    vecs[0]  = '{1'b1, 8'h80, 5'b00110, 5'b11111, 4'd4,  8'h80, 5'b00110, 1'b1}; // MI
    vecs[1]  = '{1'b1, 8'h00, 5'b00001, 5'b11111, 4'd2,  8'h00, 5'b00001, 1'b1}; // EQ fwd
    vecs[2]  = '{1'b1, 8'h55, 5'b10000, 5'b11111, 4'd14, 8'h55, 5'b10000, 1'b1}; // HI C=1 Z=0
    vecs[3]  = '{1'b1, 8'h00, 5'b00001, 5'b00001, 4'd14, 8'h00, 5'b10001, 1'b0}; // HI Z=1
    vecs[4]  = '{1'b0, 8'hAA, 5'b00000, 5'b11111, 4'd15, 8'h00, 5'b10001, 1'b1}; // LS
    vecs[5]  = '{1'b1, 8'h7F, 5'b01000, 5'b01000, 4'd10, 8'h7F, 5'b11001, 1'b1}; // LT
    vecs[6]  = '{1'b1, 8'h01, 5'b00000, 5'b01001, 4'd11, 8'h01, 5'b10000, 1'b1}; // GE
    vecs[7]  = '{1'b1, 8'h02, 5'b11111, 5'b00000, 4'd12, 8'h02, 5'b10000, 1'b1}; // GT, mask 0
    vecs[8]  = '{1'b1, 8'h03, 5'b00010, 5'b00010, 4'd13, 8'h03, 5'b10010, 1'b1}; // LE
    vecs[9]  = '{1'b0, 8'h00, 5'b00000, 5'b00000, 4'd1,  8'h03, 5'b10010, 1'b0}; // NV
    vecs[10] = '{1'b0, 8'h00, 5'b00000, 5'b00000, 4'd9,  8'h03, 5'b10010, 1'b0}; // CC
    vecs[11] = '{1'b1, 8'h04, 5'b01000, 5'b01000, 4'd6,  8'h04, 5'b11010, 1'b1}; // VS
    vecs[12] = '{1'b0, 8'h00, 5'b00000, 5'b00000, 4'd5,  8'h04, 5'b11010, 1'b0}; // PL
    vecs[13] = '{1'b0, 8'h00, 5'b00000, 5'b00000, 4'd0,  8'h04, 5'b11010, 1'b1}; // AL

    step(); step();
    reset = 1'b0;
    check("rst_acc", acc, 8'h00);
    check("rst_flags", flags, 5'd0);
    check("rst_cond_ready", cond_ready, 1'b1);
    check("rst_taken_valid", taken_valid, 1'b0);
    check("rst_taken", taken, 1'b0);
    check("rst_full", stack_full, 1'b0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_err", stack_err, 1'b0);

    for (int i = 0; i < 14; i++) begin
      set_alu(vecs[i].rv, vecs[i].res, vecs[i].fin, vecs[i].we);
      cond_valid = 1'b1;
      cond       = vecs[i].cond;
      step();
      set_alu(1'b0, 8'h00, 5'd0, 5'd0);
      cond_valid = 1'b0;
      check($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
      check($sformatf("v%0d_flags", i), flags, vecs[i].exp_flags);
      check($sformatf("v%0d_taken_valid", i), taken_valid, 1'b1);
      check($sformatf("v%0d_taken", i), taken, vecs[i].exp_taken);
      taken_ack = 1'b1;
      step();
      taken_ack = 1'b0;
      check($sformatf("v%0d_ready_after_ack", i), cond_ready, 1'b1);
      check($sformatf("v%0d_valid_after_ack", i), taken_valid, 1'b0);
    end

    // Held decision: flags 11010, MI -> 1; flags cleared meanwhile must not disturb it
    cond_valid = 1'b1; cond = 4'd4;
    step();
    cond_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) set_alu(1'b1, 8'h11, 5'b00000, 5'b11111);
      else        set_alu(1'b0, 8'h00, 5'd0, 5'd0);
      check($sformatf("hold%0d_valid", k), taken_valid, 1'b1);
      check($sformatf("hold%0d_taken", k), taken, 1'b1);
      check($sformatf("hold%0d_ready", k), cond_ready, 1'b0);
      step();
    end
    check("hold_flags_updated", flags, 5'b00000);
    check("hold_acc_updated", acc, 8'h11);
    check("hold_still_taken", taken, 1'b1);
    taken_ack = 1'b1;
    step();
    taken_ack = 1'b0;
    check("hold_ready_after_ack", cond_ready, 1'b1);

    // Reset while a decision is pending
    set_alu(1'b1, 8'h22, 5'b11111, 5'b11111);
    cond_valid = 1'b1; cond = 4'd0;
    step();
    set_alu(1'b0, 8'h00, 5'd0, 5'd0);
    cond_valid = 1'b0;
    check("pre_rst_valid", taken_valid, 1'b1);
    check("pre_rst_flags", flags, 5'b11111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", taken_valid, 1'b0);
    check("mid_rst_acc", acc, 8'h00);
    check("mid_rst_flags", flags, 5'd0);
    check("mid_rst_empty", stack_empty, 1'b1);
    check("mid_rst_ready", cond_ready, 1'b1);

`ifdef ALU_FLAG_STACK_EN
    // Each push stores the flags from before the same-cycle ALU write
    push = 1'b1;
    set_alu(1'b1, 8'h01, 5'b00001, 5'b11111); step();
    set_alu(1'b1, 8'h02, 5'b00010, 5'b11111); step();
    set_alu(1'b1, 8'h03, 5'b00100, 5'b11111); step();
    set_alu(1'b1, 8'h04, 5'b01000, 5'b11111); step();
    set_alu(1'b0, 8'h00, 5'd0, 5'd0);
    check("stk_full", stack_full, 1'b1);
    check("stk_err_before", stack_err, 1'b0);
    check("stk_flags_after_push", flags, 5'b01000);
    step();
    push = 1'b0;
    check("stk_err_overflow", stack_err, 1'b1);
    check("stk_still_full", stack_full, 1'b1);
    set_alu(1'b1, 8'h05, 5'b10000, 5'b11111); step();
    set_alu(1'b0, 8'h00, 5'd0, 5'd0);
    check("stk_flags_changed", flags, 5'b10000);
    pop = 1'b1; step(); pop = 1'b0;
    check("stk_pop_flags", flags, 5'b00100);
    check("stk_not_full", stack_full, 1'b0);
    pop = 1'b1;
    set_alu(1'b1, 8'h66, 5'b11111, 5'b11111); step();
    set_alu(1'b0, 8'h00, 5'd0, 5'd0); pop = 1'b0;
    check("stk_pop_over_write", flags, 5'b00010);
    check("stk_pop_acc", acc, 8'h66);
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    check("stk_pushpop_flags", flags, 5'b00010);
    pop = 1'b1; step();
    check("stk_pop3", flags, 5'b00001);
    step();
    check("stk_pop4", flags, 5'b00000);
    check("stk_empty", stack_empty, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("stk_err_cleared", stack_err, 1'b0);
    pop = 1'b1; step(); pop = 1'b0;
    check("stk_err_underflow", stack_err, 1'b1);
`else
    set_alu(1'b1, 8'h09, 5'b10101, 5'b11111);
    push = 1'b1; step(); push = 1'b0;
    set_alu(1'b0, 8'h00, 5'd0, 5'd0);
    pop = 1'b1; step(); step(); pop = 1'b0;
    check("nostk_flags", flags, 5'b10101);
    check("nostk_full", stack_full, 1'b0);
    check("nostk_empty", stack_empty, 1'b1);
    check("nostk_err", stack_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
